pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 201 ++++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_stage_reg                                               |
// | Description : Valid/ready pipeline register between two processor stages. |
// |               Carries a control field and a payload field as one entry.   |
// |               out_ctrl is forced to zero whenever no entry is presented, |
// |               so a bubble never enables a write, memory or branch action. |
// |                                                                            |
// | Build option: PIPE_STAGE_SKID_EN                                           |
// |   defined   -> two entries (main + skid), in_ready is registered and has  |
// |                no combinational path from out_ready.                       |
// |   undefined -> one entry, in_ready = !out_valid | out_ready.               |
// |                                                                            |
// | Ports:                                                                     |
// |   clk, rst          rising-edge clock, synchronous active-high reset       |
// |   flush             synchronous kill of every held entry                   |
// |   in_valid/in_ready upstream handshake, in_ctrl/in_data upstream entry     |
// |   out_valid/out_ready downstream handshake, out_ctrl/out_data head entry   |
// |                                                                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module pipe_stage_reg #(
   parameter int CTRL_W = 9,
   parameter int DATA_W = 141
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
);

   logic              accept;
   logic              drain;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;

   assign accept   = in_valid & in_ready;
   assign drain    = out_valid & out_ready;
   // The main entry is always the head; its ctrl is cleared whenever the
   // stage empties, so no output gating is needed to keep bubbles inert.
   assign out_ctrl = main_ctrl_q;
   assign out_data = main_data_q;

`ifdef PIPE_STAGE_SKID_EN

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              main_valid;
   logic              skid_valid;

   assign main_valid = (state_q != ST_EMPTY);
   assign skid_valid = (state_q == ST_TWO);
   assign out_valid  = main_valid;
   // Depends only on state, so out_ready never reaches in_ready.
   assign in_ready   = !skid_valid;

   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      if (flush) begin
         state_d     = ST_EMPTY;
         main_ctrl_d = '0;
         main_data_d = '0;
         skid_ctrl_d = '0;
         skid_data_d = '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d     = ST_ONE;
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end
            end
            ST_ONE: begin
               if (accept && !drain) begin
                  // Head is stalled: park the newcomer behind it.
                  state_d     = ST_TWO;
                  skid_ctrl_d = in_ctrl;
                  skid_data_d = in_data;
               end else if (accept && drain) begin
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end else if (drain) begin
                  // Data keeps the last head value; ctrl must read as a bubble.
                  state_d     = ST_EMPTY;
                  main_ctrl_d = '0;
               end
            end
            ST_TWO: begin
               if (drain) begin
                  state_d     = ST_ONE;
                  main_ctrl_d = skid_ctrl_q;
                  main_data_d = skid_data_q;
                  skid_ctrl_d = '0;
                  skid_data_d = '0;
               end
            end
            default: begin
               state_d     = ST_EMPTY;
               main_ctrl_d = '0;
               main_data_d = '0;
               skid_ctrl_d = '0;
               skid_data_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else begin
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
      end
   end

`else

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t state_q, state_d;

   assign out_valid = (state_q == ST_FULL);
   // A full stage can still accept when its head leaves in the same cycle.
   assign in_ready  = !out_valid | out_ready;

   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      if (flush) begin
         state_d     = ST_EMPTY;
         main_ctrl_d = '0;
         main_data_d = '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d     = ST_FULL;
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end
            end
            ST_FULL: begin
               if (drain && accept) begin
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end else if (drain) begin
                  state_d     = ST_EMPTY;
                  main_ctrl_d = '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_ctrl_q <= '0;
         main_data_q <= '0;
      end else begin
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
      end
   end

`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_stage_reg                                            |
// | Description : Self-checking bench for pipe_stage_reg. A queue holds the    |
// |               entries the stage is expected to contain; entries are pushed |
// |               when the bench drives an accepted transfer and popped when   |
// |               the head drains. Follows PIPE_STAGE_SKID_EN like the DUT.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_pipe_stage_reg;

   localparam int CTRL_W = 9;
   localparam int DATA_W = 141;
`ifdef PIPE_STAGE_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   typedef struct packed {
      logic [CTRL_W-1:0] c;
      logic [DATA_W-1:0] d;
   } ent_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;

   ent_t              sb_q[$];
   logic [DATA_W-1:0] last_data;
   int                n_checks = 0;
   int                n_fail   = 0;

   pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs mid-cycle against the
   // scoreboard, then advance the scoreboard across the rising edge.
   task automatic cycle(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                        input logic ordy, input logic fl, input logic rs);
      logic exp_valid;
      logic exp_ready;
      logic acc;
      logic drn;
      ent_t e;
      in_valid  = v;
      in_ctrl   = c;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      rst       = rs;
      #3;
      exp_valid = (sb_q.size() > 0);
`ifdef PIPE_STAGE_SKID_EN
      exp_ready = (sb_q.size() < DEPTH);
`else
      exp_ready = !exp_valid || ordy;
`endif
      check_eq("out_valid", {255'd0, out_valid}, {255'd0, exp_valid});
      check_eq("in_ready", {255'd0, in_ready}, {255'd0, exp_ready});
      if (exp_valid) begin
         check_eq("out_ctrl", {{(256-CTRL_W){1'b0}}, out_ctrl}, {{(256-CTRL_W){1'b0}}, sb_q[0].c});
         check_eq("out_data", {{(256-DATA_W){1'b0}}, out_data}, {{(256-DATA_W){1'b0}}, sb_q[0].d});
      end else begin
         check_eq("bubble_ctrl", {{(256-CTRL_W){1'b0}}, out_ctrl}, 256'd0);
         check_eq("bubble_data", {{(256-DATA_W){1'b0}}, out_data}, {{(256-DATA_W){1'b0}}, last_data});
      end
      acc = v && exp_ready;
      drn = exp_valid && ordy;
      @(posedge clk);
      if (rs || fl) begin
         sb_q.delete();
         last_data = '0;
      end else begin
         if (drn) void'(sb_q.pop_front());
         if (acc) begin
            e.c = c;
            e.d = d;
            sb_q.push_back(e);
         end
         if (sb_q.size() > 0) last_data = sb_q[0].d;
      end
      #1;
   endtask

   function automatic logic [DATA_W-1:0] rnd_data();
      logic [159:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return t[DATA_W-1:0];
   endfunction

   initial begin
      logic [CTRL_W-1:0] rc;
      last_data = '0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ctrl = '0; in_data = '0;
      @(posedge clk);
      #1;
      // Reset state, then a single accept emerging one cycle later.
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 9'h1A5, 141'h1234, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

      // Back-to-back stream of eight entries with the sink always ready.
      for (int i = 0; i < 8; i++)
         cycle(1'b1, CTRL_W'(i + 1), DATA_W'(i), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

      // Fill while stalled, then release: order and in_ready recovery.
      cycle(1'b1, 9'h011, 141'h100, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 9'h022, 141'h101, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 9'h033, 141'h102, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

      // Flush while full with a new entry offered: nothing survives.
      cycle(1'b1, 9'h044, 141'h200, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 9'h055, 141'h201, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 9'h066, 141'h202, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

      // Reset and flush together with an entry held and out_ready toggling.
      cycle(1'b1, 9'h077, 141'h300, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 9'h088, 141'h301, 1'b1, 1'b1, 1'b1);
      cycle(1'b1, 9'h099, 141'h302, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

      // Random handshakes with occasional flush and reset.
      for (int i = 0; i < 10000; i++) begin
         rc = CTRL_W'($urandom);
         cycle(1'($urandom_range(0, 3) != 0), rc, rnd_data(),
               1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 99) == 0),
               1'($urandom_range(0, 499) == 0));
      end
      for (int i = 0; i < 4; i++)
         cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
